laser_bank: RTL and testbench
=============================

# laser_bank

Multi-shot player laser manager for the Space Invaders datapath. Tracks up to NUM_SHOTS independent lasers, spawns them at the gun on fire with a refire cooldown, moves them upward once per game tick, and retires them on alien hit or when they leave the screen. It sits between the ship/gun logic and the collision and VGA colour mux, and supplies per-slot positions plus a registered per-pixel laser colour.

## Interface
Parameters:
- NUM_SHOTS, 4: number of laser slots (1..8).
- RADIUS, 4: laser disc radius in pixels.
- STEP_MOTION, 2: upward pixels per tick.
- COOLDOWN, 16: ticks between successive spawns.
- SCREEN_WIDTH, 640 / SCREEN_HEIGHT, 480: visible area.
- SHIP_HEIGHT, 30 / V_OFFSET, 10: ship geometry for the spawn row.
- LASER, 6 / BACKGROUND, 0: colour codes.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  game tick; one-cycle pulse, once per frame.
- fire  in  1  fire request, sampled on enable cycles only.
- gunPosition  in  10  gun x-centre.
- kill  in  NUM_SHOTS  per-slot alien-hit flags, sampled on enable cycles.
- hPos, vPos  in  10 each  current VGA pixel.
- xLaser  out  10*NUM_SHOTS  packed slot x; slot i is bits [10i+9:10i].
- yLaser  out  10*NUM_SHOTS  packed slot y.
- alive  out  NUM_SHOTS  slot-active flags.
- colorLaser  out  3  registered pixel colour.

## Operation
- Parked slot: x = SCREEN_WIDTH-1, y = SCREEN_HEIGHT-1, alive = 0.
- All state updates occur only on cycles with enable = 1, except colour and reset.
- Per slot, evaluated in this priority order on a tick:
  - alive and kill[i]: retire and park.
  - alive and y < STEP_MOTION: retire and park.
  - alive otherwise: y <= y - STEP_MOTION.
  - not alive: kill[i] is ignored.
- Spawn: a fire request is accepted when cooldown = 0 and at least one slot was free before the tick.
  - The accepted request claims the lowest-index free slot.
  - That slot is set to x = gunPosition, y = SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT - RADIUS (436 at defaults), alive = 1.
  - The cooldown counter loads COOLDOWN.
- A slot retired in a tick is not reused in that same tick.
- Fire with all slots busy, or with cooldown > 0, is dropped; the cooldown is not reloaded.
- The cooldown counter decrements by 1 each tick while nonzero. It is $clog2(COOLDOWN+1) bits wide and saturates at 0.
- Colour, every clk: colorLaser <= LASER if any alive slot i has dx*dx + dy*dy <= RADIUS*RADIUS, else BACKGROUND.
  - dx = hPos - x_i and dy = vPos - y_i, computed as 11-bit signed values. Squares and their sum are 22-bit unsigned.
  - No wrap-around artefacts are allowed.

## Timing
- Reset values: all slots parked, alive = 0, cooldown = 0, colorLaser = BACKGROUND, fire history = 0.
- Reset has priority over enable. Reset asserted mid-flight clears all slots on the next edge.
- Slot outputs change on the clock edge that samples enable = 1, so they are visible one cycle after the tick.
- colorLaser has a latency of 1 clk from hPos/vPos and reflects the slot state as of the previous cycle.
- A spawn and motion on other slots happen in the same tick. A newly spawned slot does not move until the next tick.

## Configuration
- LASER_BANK_AUTOFIRE_EN defined: a held fire spawns again as soon as the cooldown reaches 0, provided a slot is free.
- Undefined: fire is rising-edge detected across enable ticks.
  - A fire_prev register is updated only on ticks.
  - A spawn requires fire = 1 and fire_prev = 0.
  - A dropped edge is lost.

## Test plan
- Reset, then fire on one tick with gunPosition = 320 -> slot 0 at (320,436) and alive = 0001; cooldown = 16. Next tick, y = 434.
- Hold fire for 100 ticks with AUTOFIRE_EN -> spawns on ticks 0, 17, 34 and 51 into slots 0-3. No spawn on tick 68 while all slots are busy.
- Slot at y = 1 with STEP = 2 -> retired and parked at (639,479). With fire on the same tick and all other slots busy, the retired slot is not reused until the next tick.
- kill = 0010 with slots 0-1 alive -> only slot 1 parks. A kill on a dead slot has no effect.
- Slot at (5,5) with pixel (1,5) and R = 4 -> LASER one clk later. Pixel (0,5) -> BACKGROUND. Pixel (639,5) -> BACKGROUND, confirming no unsigned wrap.
- Assert reset mid-flight with 3 slots alive and cooldown = 9 -> all slots parked, cooldown = 0, and a fire on the next tick spawns immediately.

Source files
------------

// File: rtl/laser_bank.sv
// Multi-shot player laser manager: spawns, moves and retires up to NUM_SHOTS lasers and
// draws them as discs. Define LASER_BANK_AUTOFIRE_EN to let a held fire keep spawning.
module laser_bank #(
    parameter int NUM_SHOTS     = 4,
    parameter int RADIUS        = 4,
    parameter int STEP_MOTION   = 2,
    parameter int COOLDOWN      = 16,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int SHIP_HEIGHT   = 30,
    parameter int V_OFFSET      = 10,
    parameter int LASER         = 6,
    parameter int BACKGROUND    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fire,
    input  logic [9:0]             gunPosition,
    input  logic [NUM_SHOTS-1:0]   kill,
    input  logic [9:0]             hPos,
    input  logic [9:0]             vPos,
    output logic [10*NUM_SHOTS-1:0] xLaser,
    output logic [10*NUM_SHOTS-1:0] yLaser,
    output logic [NUM_SHOTS-1:0]   alive,
    output logic [2:0]             colorLaser
);

    localparam logic [9:0]  X_PARK  = 10'(SCREEN_WIDTH - 1);
    localparam logic [9:0]  Y_PARK  = 10'(SCREEN_HEIGHT - 1);
    localparam logic [9:0]  Y_SPAWN = 10'(SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT - RADIUS);
    localparam logic [9:0]  STEP    = 10'(STEP_MOTION);
    localparam logic [21:0] R_SQ    = 22'(RADIUS * RADIUS);
    localparam int          CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

    logic [9:0]           x_q [NUM_SHOTS];
    logic [9:0]           x_d [NUM_SHOTS];
    logic [9:0]           y_q [NUM_SHOTS];
    logic [9:0]           y_d [NUM_SHOTS];
    logic [NUM_SHOTS-1:0] alive_q, alive_d;
    logic [CD_W-1:0]      cooldown_q, cooldown_d;
    logic [2:0]           color_q, color_d;
    logic [NUM_SHOTS-1:0] spawn_sel;
    logic                 fire_req;
    logic                 spawn;

    // Distances are formed as 11-bit two's complement so a pixel left of the laser
    // yields a small negative dx rather than a large unsigned one.
    function automatic logic [21:0] dist_sq(input logic [9:0] ax, input logic [9:0] ay,
                                            input logic [9:0] bx, input logic [9:0] by);
        logic [10:0] dx, dy, adx, ady;
        dx  = {1'b0, ax} - {1'b0, bx};
        dy  = {1'b0, ay} - {1'b0, by};
        adx = dx[10] ? (11'd0 - dx) : dx;
        ady = dy[10] ? (11'd0 - dy) : dy;
        return ({11'd0, adx} * {11'd0, adx}) + ({11'd0, ady} * {11'd0, ady});
    endfunction

`ifdef LASER_BANK_AUTOFIRE_EN
    assign fire_req = fire;
`else
    logic fire_prev_q, fire_prev_d;

    assign fire_req    = fire & ~fire_prev_q;
    assign fire_prev_d = enable ? fire : fire_prev_q;

    always_ff @(posedge clk) begin
        if (reset) fire_prev_q <= 1'b0;
        else       fire_prev_q <= fire_prev_d;
    end
`endif

    // Lowest clear bit of the pre-tick alive vector; slots retiring this tick stay unused.
    assign spawn_sel = ~alive_q & (alive_q + NUM_SHOTS'(1));
    assign spawn     = enable & fire_req & (cooldown_q == '0) & (|spawn_sel);

    always_comb begin
        alive_d    = alive_q;
        cooldown_d = cooldown_q;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            if (enable) begin
                if (alive_q[i]) begin
                    if (kill[i] || (y_q[i] < STEP)) begin
                        x_d[i]     = X_PARK;
                        y_d[i]     = Y_PARK;
                        alive_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_q[i] - STEP;
                    end
                end else if (spawn && spawn_sel[i]) begin
                    x_d[i]     = gunPosition;
                    y_d[i]     = Y_SPAWN;
                    alive_d[i] = 1'b1;
                end
            end
        end
        if (enable) begin
            if (spawn)                   cooldown_d = CD_LOAD;
            else if (cooldown_q != '0)   cooldown_d = cooldown_q - CD_W'(1);
        end
    end

    always_comb begin
        color_d = 3'(BACKGROUND);
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (alive_q[i] && (dist_sq(hPos, vPos, x_q[i], y_q[i]) <= R_SQ))
                color_d = 3'(LASER);
        end
    end

    // NOTE: state registers use non-blocking assignments so every slot updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SHOTS; i++) begin
                x_q[i] <= X_PARK;
                y_q[i] <= Y_PARK;
            end
            alive_q    <= '0;
            cooldown_q <= '0;
            color_q    <= 3'(BACKGROUND);
        end else begin
            for (int i = 0; i < NUM_SHOTS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
            alive_q    <= alive_d;
            cooldown_q <= cooldown_d;
            color_q    <= color_d;
        end
    end

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_pack
        assign xLaser[10*g +: 10] = x_q[g];
        assign yLaser[10*g +: 10] = y_q[g];
    end

    assign alive      = alive_q;
    assign colorLaser = color_q;

endmodule

// File: tb/tb_laser_bank.sv
// Scoreboard bench for laser_bank: stimulus queues hand-computed expectations, and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_laser_bank;

    localparam logic [2:0] LASER = 3'd6;
    localparam logic [2:0] BG    = 3'd0;

    logic        clk = 1'b0;
    logic        reset, enable, fire;
    logic [9:0]  gunPosition, hPos, vPos;
    logic [3:0]  kill;
    logic [39:0] xLaser, yLaser;
    logic [3:0]  alive;
    logic [2:0]  colorLaser;

    always #5 clk = ~clk;

    laser_bank dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fire       (fire),
        .gunPosition(gunPosition),
        .kill       (kill),
        .hPos       (hPos),
        .vPos       (vPos),
        .xLaser     (xLaser),
        .yLaser     (yLaser),
        .alive      (alive),
        .colorLaser (colorLaser)
    );

    typedef enum {K_ALIVE, K_X, K_Y, K_COLOR} kind_t;
    typedef struct {
        string name;
        kind_t kind;
        int    slot;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input string name, input kind_t k, input int slot, input int e);
        exp_t item;
        item.name = name;
        item.kind = k;
        item.slot = slot;
        item.exp  = e;
        sb.push_back(item);
    endtask

    task automatic push_slot(input string name, input int slot, input int x, input int y);
        push({name, "_x"}, K_X, slot, x);
        push({name, "_y"}, K_Y, slot, y);
    endtask

    // Monitor: outputs are stable at the negedge following each driven posedge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_ALIVE: got = 32'(alive);
                K_X:     got = 32'(xLaser[10*e.slot +: 10]);
                K_Y:     got = 32'(yLaser[10*e.slot +: 10]);
                default: got = 32'(colorLaser);
            endcase
            check(e.name, got, 32'(e.exp));
        end
    end

    task automatic tick(input logic f, input logic [3:0] k);
        @(negedge clk);
        fire   = f;
        kill   = k;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        fire   = 1'b0;
        kill   = '0;
    endtask

    task automatic idle_ticks(input int n);
        repeat (n) tick(1'b0, 4'b0000);
    endtask

    // Reset is held with enable and fire high to confirm reset wins.
    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        fire   = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b0;
        fire   = 1'b0;
    endtask

    task automatic pix(input string name, input int h, input int v, input logic [2:0] e);
        @(negedge clk);
        hPos = 10'(h);
        vPos = 10'(v);
        @(posedge clk);
        #1;
        push(name, K_COLOR, 0, int'(e));
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; fire = 1'b0; kill = '0;
        gunPosition = '0; hPos = '0; vPos = '0;

        // Reset state
        do_reset();
        push("rst_alive", K_ALIVE, 0, 0);
        push_slot("rst_s0", 0, 639, 479);
        push_slot("rst_s3", 3, 639, 479);
        push("rst_color", K_COLOR, 0, int'(BG));

        // First spawn and motion
        gunPosition = 10'd320;
        tick(1'b1, 4'b0000);
        push("spawn_alive", K_ALIVE, 0, 4'b0001);
        push_slot("spawn_s0", 0, 320, 436);
        tick(1'b0, 4'b0000);
        push("move_s0_y", K_Y, 0, 434);

        // Fire during cooldown is dropped, including with one tick left
        tick(1'b1, 4'b0000);
        push("cd15_alive", K_ALIVE, 0, 4'b0001);
        push("cd15_s0_y", K_Y, 0, 432);
        idle_ticks(13);
        tick(1'b1, 4'b0000);
        push("cd1_alive", K_ALIVE, 0, 4'b0001);
        push("cd1_s0_y", K_Y, 0, 404);
        tick(1'b0, 4'b0000);
        gunPosition = 10'd100;
        tick(1'b1, 4'b0000);
        push("cd0_alive", K_ALIVE, 0, 4'b0011);
        push_slot("cd0_s1", 1, 100, 436);
        push("cd0_s0_y", K_Y, 0, 400);

        // Kill only affects live slots
        tick(1'b0, 4'b0010);
        push("kill1_alive", K_ALIVE, 0, 4'b0001);
        push_slot("kill1_s1", 1, 639, 479);
        push("kill1_s0_y", K_Y, 0, 398);
        tick(1'b0, 4'b1100);
        push("killdead_alive", K_ALIVE, 0, 4'b0001);
        push("killdead_s0_y", K_Y, 0, 396);
        push_slot("killdead_s2", 2, 639, 479);

        // Mid-flight reset, then a fresh bank for colour and retirement
        do_reset();
        push("rst2_alive", K_ALIVE, 0, 0);
        push_slot("rst2_s0", 0, 639, 479);
        gunPosition = 10'd5;
        tick(1'b1, 4'b0000);
        push("t0_alive", K_ALIVE, 0, 4'b0001);
        push_slot("t0_s0", 0, 5, 436);

        pix("pix_dx_m4", 1, 436, LASER);
        pix("pix_dx_m5", 0, 436, BG);
        pix("pix_wrap", 639, 436, BG);
        pix("pix_dy_m4", 5, 432, LASER);
        pix("pix_dy_m5", 5, 431, BG);
        pix("pix_diag8", 7, 438, LASER);
        pix("pix_diag18", 8, 439, BG);
        pix("pix_dx_p4", 9, 436, LASER);

        idle_ticks(17);
        gunPosition = 10'd200;
        tick(1'b1, 4'b0000);
        push("t18_alive", K_ALIVE, 0, 4'b0011);
        push_slot("t18_s1", 1, 200, 436);
        push("t18_s0_y", K_Y, 0, 400);
        idle_ticks(17);
        gunPosition = 10'd300;
        tick(1'b1, 4'b0000);
        push("t36_alive", K_ALIVE, 0, 4'b0111);
        push_slot("t36_s2", 2, 300, 436);
        idle_ticks(17);
        gunPosition = 10'd400;
        tick(1'b1, 4'b0000);
        push("t54_alive", K_ALIVE, 0, 4'b1111);
        push_slot("t54_s3", 3, 400, 436);
        push("t54_s0_y", K_Y, 0, 328);

        idle_ticks(162);
        tick(1'b0, 4'b0000);
        push("t217_s0_y", K_Y, 0, 2);
        tick(1'b0, 4'b0000);
        push("t218_s0_y", K_Y, 0, 0);
        push("t218_alive", K_ALIVE, 0, 4'b1111);
        gunPosition = 10'd50;
        tick(1'b1, 4'b0000);
        push("retire_alive", K_ALIVE, 0, 4'b1110);
        push_slot("retire_s0", 0, 639, 479);
        tick(1'b0, 4'b0000);
        push("t220_alive", K_ALIVE, 0, 4'b1110);
        tick(1'b1, 4'b0000);
        push("reuse_alive", K_ALIVE, 0, 4'b1111);
        push_slot("reuse_s0", 0, 50, 436);
        push("reuse_s1_y", K_Y, 1, 30);
        push("reuse_s2_y", K_Y, 2, 66);
        push("reuse_s3_y", K_Y, 3, 102);

        // Three alive, cooldown at 9, then reset and immediate spawn
        tick(1'b0, 4'b1000);
        push("t222_alive", K_ALIVE, 0, 4'b0111);
        idle_ticks(6);
        push("t228_alive", K_ALIVE, 0, 4'b0111);
        do_reset();
        push("rst3_alive", K_ALIVE, 0, 0);
        push_slot("rst3_s1", 1, 639, 479);
        push_slot("rst3_s2", 2, 639, 479);
        pix("pix_parked_dead", 639, 479, BG);
        gunPosition = 10'd77;
        tick(1'b1, 4'b0000);
        push("rst3_spawn_alive", K_ALIVE, 0, 4'b0001);
        push_slot("rst3_spawn_s0", 0, 77, 436);

        // Held fire for 100 ticks
        do_reset();
        gunPosition = 10'd10;
        for (int t = 0; t < 100; t++) begin
            tick(1'b1, 4'b0000);
`ifdef LASER_BANK_AUTOFIRE_EN
            case (t)
                0, 16:  push($sformatf("hold_t%0d_alive", t), K_ALIVE, 0, 4'b0001);
                17:     push("hold_t17_alive", K_ALIVE, 0, 4'b0011);
                34:     push("hold_t34_alive", K_ALIVE, 0, 4'b0111);
                51:     push("hold_t51_alive", K_ALIVE, 0, 4'b1111);
                68: begin
                    push("hold_t68_alive", K_ALIVE, 0, 4'b1111);
                    push_slot("hold_t68_s0", 0, 10, 300);
                end
                default: ;
            endcase
`else
            if (t == 0 || t == 17 || t == 51 || t == 68)
                push($sformatf("hold_t%0d_alive", t), K_ALIVE, 0, 4'b0001);
            if (t == 68)
                push_slot("hold_t68_s0", 0, 10, 300);
`endif
        end

        repeat (3) @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
